serial_addsub_arbiter: RTL and testbench
========================================

# serial_addsub_arbiter

Bit-serial add/subtract engine that shares one 1-bit `fullAdder` cell between two requesters. The block arbitrates round-robin, computes a WIDTH-bit two's-complement sum or difference LSB-first over WIDTH cycles, and returns the result with carry, overflow and zero flags on a valid/ready result port. It sits beside the CPU ALU as a low-area arithmetic resource for multi-cycle address and counter updates.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥2)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands
- `req0_sub`  in  1  requester 0: 0 = a+b, 1 = a−b
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`  same as requester 0, for requester 1
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  WIDTH  sum/difference
- `res_id`  out  1  index of requester that issued this result
- `res_cf`  out  1  final carry out (sub: 1 = no borrow)
- `res_of`  out  1  signed overflow
- `res_zf`  out  1  `res_data` == 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: grant computed combinationally. Only one valid → grant it. Both valid → grant the requester not equal to `last_grant`. `reqN_ready` = 1 only for the granted requester in IDLE. On accept edge: latch a, b, sub, id; carry ← sub; bit counter ← 0; `last_grant` ← id; go RUN.
- RUN: each cycle the cell gets a[0], b[0], carry, mode=sub. Sum bit shifts into the result MSB and the result shifts right. a and b shift right; carry ← cell cf. Carry into the MSB is captured when counter == WIDTH−1. After the cycle with counter == WIDTH−1, go DONE.
- DONE: `res_valid` = 1. `res_data` and the flags are held stable. `res_cf` = final carry. `res_of` = carry-into-MSB XOR final carry. `res_zf` = (res_data == 0). On `res_valid && res_ready` edge, go IDLE.
- Requesters must hold valid and operands stable until ready. Deasserting valid before acceptance is permitted in IDLE and simply drops the request.
- No new request is accepted in RUN or DONE. Both readies are 0 in those states.

## Timing
- Reset (async assert, sync release): state IDLE, `last_grant` = 1 (req0 wins first tie). `res_valid`, `res_data`, `res_id` and all flags = 0. Any in-flight operation is discarded.
- Reset mid-RUN or mid-DONE: outputs go to reset values immediately, with no clock required.
- Accept at edge E. RUN occupies WIDTH cycles. `res_valid` rises after edge E+WIDTH.
- Handshake at DONE edge D. Earliest next accept is at edge D+1, because IDLE lasts at least one cycle and there is no bypass. Minimum issue interval is WIDTH+2 cycles.
- `res_valid` never drops without `res_ready`.
- Counter width is $clog2(WIDTH). The counter does not wrap past WIDTH−1.

## Structure
- A shared package holds the state enumeration (IDLE/RUN/DONE) and the counter-width function.
- Sub-module: exactly one instance of the existing `fullAdder` (a, b, c, mode → s, cf) as the bit cell.
- All other logic is in this module: arbiter, shift registers, counter and flag logic.

## Test plan
All cases use WIDTH=8.
- req0: a=0x05, b=0x03, add → res_data=0x08, cf=0, of=0, zf=0, id=0. `res_valid` rises 8 cycles after accept.
- req1: 0x03−0x05 → 0xFE, cf=0, of=0, zf=0. Then 0x05−0x05 → 0x00, cf=1, zf=1.
- 0x7F+0x01 → 0x80, of=1, cf=0. Then 0x80−0x01 → 0x7F, of=1, cf=1. Then 0xFF+0x01 → 0x00, cf=1, zf=1, of=0.
- Both requesters held valid for 4 operations, `res_ready`=1 → grants 0,1,0,1. Each `res_id` matches its issuer. Accepts are spaced exactly 10 cycles apart.
- `res_ready` held 0 for 5 cycles in DONE → `res_valid`, data and flags stable. Both readies stay 0. Accept occurs only after the handshake.
- Assert `rst_n`=0 at RUN cycle 4 → `res_valid`=0 and state IDLE with no clock. After release, with both valid → req0 granted.

Source files
------------

// File: rtl/serial_addsub_arbiter_pkg.sv
// Shared types and helpers for the bit-serial add/subtract engine.
package serial_addsub_arbiter_pkg;

   // Engine sequencing: wait for a request, shift WIDTH bits, present result.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bit-counter width for a WIDTH-bit operand; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      int unsigned r;
      r = $clog2(w);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/serial_addsub_arbiter_fulladder.sv
// One-bit full adder cell with built-in subtract mode (b inverted when mode=1).
module fullAdder (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic mode,
   output logic s,
   output logic cf
);

   logic w_bx;

   assign w_bx = b ^ mode;
   assign s    = a ^ w_bx ^ c;
   assign cf   = (a & w_bx) | (a & c) | (w_bx & c);

endmodule

// File: rtl/serial_addsub_arbiter.sv
// Round-robin arbitrated, bit-serial WIDTH-bit add/subtract engine.
// One shared fullAdder cell processes operands LSB-first; the result is
// returned with carry, overflow and zero flags on a valid/ready port.
module serial_addsub_arbiter
   import serial_addsub_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_id,
   output logic             res_cf,
   output logic             res_of,
   output logic             res_zf
);

   localparam int unsigned   CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_sub;
   logic             r_id;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic             r_last_grant;
   logic             r_cf;
   logic             r_of;
   logic             r_zf;

   logic             w_gnt_id;
   logic             w_accept;
   logic             w_last;
   logic             w_cell_s;
   logic             w_cell_cf;
   logic [WIDTH-1:0] w_res_shift;

   // Shared bit cell: LSBs of the shifting operands plus the running carry.
   fullAdder u_cell (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .c    (r_carry),
      .mode (r_sub),
      .s    (w_cell_s),
      .cf   (w_cell_cf)
   );

   assign w_last      = (r_cnt == LAST_BIT);
   assign w_res_shift = {w_cell_s, r_res[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_next_state = ST_RUN;
         ST_RUN:  if (w_last)    w_next_state = ST_DONE;
         ST_DONE: if (res_ready) w_next_state = ST_IDLE;
         default:                w_next_state = ST_IDLE;
      endcase
   end

   // Outputs: round-robin grant, request readies and result valid.
   always_comb begin
      w_gnt_id   = 1'b0;
      w_accept   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      res_valid  = 1'b0;
      if (req0_valid && req1_valid) w_gnt_id = ~r_last_grant;
      else if (req1_valid)          w_gnt_id = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_accept   = req0_valid | req1_valid;
            req0_ready = w_accept & ~w_gnt_id;
            req1_ready = w_accept &  w_gnt_id;
         end
         ST_DONE: res_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand capture, serial shift, and flag capture on the MSB.
   // Carry entering the MSB is r_carry during the last RUN cycle, so overflow
   // is taken there directly instead of keeping a separate register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a          <= '0;
         r_b          <= '0;
         r_res        <= '0;
         r_sub        <= 1'b0;
         r_id         <= 1'b0;
         r_carry      <= 1'b0;
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
         r_cf         <= 1'b0;
         r_of         <= 1'b0;
         r_zf         <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a          <= w_gnt_id ? req1_a   : req0_a;
                  r_b          <= w_gnt_id ? req1_b   : req0_b;
                  r_sub        <= w_gnt_id ? req1_sub : req0_sub;
                  r_carry      <= w_gnt_id ? req1_sub : req0_sub;
                  r_id         <= w_gnt_id;
                  r_last_grant <= w_gnt_id;
                  r_cnt        <= '0;
                  r_res        <= '0;
                  r_cf         <= 1'b0;
                  r_of         <= 1'b0;
                  r_zf         <= 1'b0;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_res   <= w_res_shift;
               r_carry <= w_cell_cf;
               if (w_last) begin
                  r_cf <= w_cell_cf;
                  r_of <= r_carry ^ w_cell_cf;
                  r_zf <= (w_res_shift == '0);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign res_data = r_res;
   assign res_id   = r_id;
   assign res_cf   = r_cf;
   assign res_of   = r_of;
   assign res_zf   = r_zf;

endmodule

// File: tb/tb_serial_addsub_arbiter.sv
// Directed bench for serial_addsub_arbiter at WIDTH=8.
module tb_serial_addsub_arbiter;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready, req0_sub;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready, req1_sub;
   logic [W-1:0] req1_a, req1_b;
   logic         res_valid, res_ready, res_id, res_cf, res_of, res_zf;
   logic [W-1:0] res_data;

   int n_vec = 0;
   int n_err = 0;

   serial_addsub_arbiter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_id     (res_id),
      .res_cf     (res_cf),
      .res_of     (res_of),
      .res_zf     (res_zf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!res_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic chk_res(input string tag, input int lat, input logic [7:0] ed,
                          input logic eid, input logic ecf, input logic eof, input logic ezf);
      chk({tag, ".lat"},  lat,      8);
      chk({tag, ".data"}, res_data, ed);
      chk({tag, ".id"},   res_id,   eid);
      chk({tag, ".cf"},   res_cf,   ecf);
      chk({tag, ".of"},   res_of,   eof);
      chk({tag, ".zf"},   res_zf,   ezf);
   endtask

   task automatic do_op(input string tag, input logic id, input logic [7:0] a,
                        input logic [7:0] b, input logic sub, input logic [7:0] ed,
                        input logic ecf, input logic eof, input logic ezf);
      int lat;
      if (!id) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
      end
      #1;
      chk({tag, ".rdy"},  id ? req1_ready : req0_ready, 1);
      chk({tag, ".nrdy"}, id ? req0_ready : req1_ready, 0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_result(lat);
      chk_res(tag, lat, ed, id, ecf, eof, ezf);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk({tag, ".drop"}, res_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      int cyc;
      int n_acc;
      int n_res;
      int acc_cyc[4];
      int acc_id[4];

      rst_n = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
      res_ready = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst.valid", res_valid, 0);
      chk("rst.data",  res_data,  0);
      chk("rst.id",    res_id,    0);
      chk("rst.cf",    res_cf,    0);
      chk("rst.of",    res_of,    0);
      chk("rst.zf",    res_zf,    0);
      chk("rst.rdy0",  req0_ready, 0);
      chk("rst.rdy1",  req1_ready, 0);
      #9 rst_n = 1'b1;
      tick();

      // Arithmetic vectors.
      do_op("add5p3",  1'b0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
      do_op("sub3m5",  1'b1, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
      do_op("sub5m5",  1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      do_op("add7Fp1", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      do_op("sub80m1", 1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
      do_op("addFFp1", 1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

      // Both requesters held valid: alternating grants, 10-cycle spacing.
      req0_a = 8'h10; req0_b = 8'h01; req0_sub = 1'b0;
      req1_a = 8'h20; req1_b = 8'h02; req1_sub = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
      n_acc = 0; n_res = 0; cyc = 0;
      for (int i = 0; i < 4; i++) begin
         acc_cyc[i] = 0;
         acc_id[i]  = 0;
      end
      #1;
      while (n_res < 4 && cyc < 80) begin
         if (req0_ready || req1_ready) begin
            if (n_acc < 4) begin
               acc_cyc[n_acc] = cyc;
               acc_id[n_acc]  = req1_ready ? 1 : 0;
            end
            n_acc++;
         end
         if (res_valid) begin
            if (n_res < n_acc && n_res < 4) begin
               chk("rr.resid", res_id, acc_id[n_res]);
               chk("rr.data",  res_data, (acc_id[n_res] == 1) ? 8'h1E : 8'h11);
               chk("rr.cf",    res_cf,   (acc_id[n_res] == 1) ? 1 : 0);
               chk("rr.of",    res_of,   0);
               chk("rr.zf",    res_zf,   0);
            end
            n_res++;
            if (n_res == 4) begin
               req0_valid = 1'b0;
               req1_valid = 1'b0;
            end
         end
         tick();
         cyc++;
      end
      res_ready = 1'b0;
      chk("rr.naccepts", n_acc, 4);
      chk("rr.nresults", n_res, 4);
      for (int i = 0; i < 4; i++) chk("rr.grant", acc_id[i], i % 2);
      for (int i = 1; i < 4; i++) chk("rr.spacing", acc_cyc[i] - acc_cyc[i-1], 10);
      chk("rr.idle", res_valid, 0);

      // Consumer stall in DONE: result held, no new accept until handshake.
      req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_sub = 1'b0;
      #1;
      tick();
      req0_valid = 1'b0;
      wait_result(lat);
      chk_res("stall", lat, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
      req1_valid = 1'b1; req1_a = 8'h30; req1_b = 8'h10; req1_sub = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("stall.valid", res_valid, 1);
         chk("stall.data",  res_data,  8'h46);
         chk("stall.id",    res_id,    0);
         chk("stall.rdy0",  req0_ready, 0);
         chk("stall.rdy1",  req1_ready, 0);
         tick();
      end
      chk("stall.held", res_valid, 1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("stall.idle",  res_valid,  0);
      chk("stall.acc1",  req1_ready, 1);
      tick();
      req1_valid = 1'b0;
      wait_result(lat);
      chk_res("post", lat, 8'h20, 1'b1, 1'b1, 1'b0, 1'b0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Asynchronous reset in RUN cycle 4, then tie goes to req0.
      req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h22; req0_sub = 1'b0;
      #1;
      chk("mrst.rdy0", req0_ready, 1);
      tick();
      req0_valid = 1'b0;
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mrst.valid", res_valid, 0);
      chk("mrst.data",  res_data,  0);
      chk("mrst.cf",    res_cf,    0);
      req0_a = 8'h0F; req0_b = 8'h01; req0_sub = 1'b0;
      req1_a = 8'h40; req1_b = 8'h01; req1_sub = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("mrst.gnt0", req0_ready, 1);
      chk("mrst.gnt1", req1_ready, 0);
      rst_n = 1'b1;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_result(lat);
      chk_res("mrst", lat, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
